// File: rtl/mfp_multi_digit_display_pwm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mfp_multi_digit_display_pwm_if                                  |
// | Brief    : Input bundle and segment/anode outputs of the display driver.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mfp_multi_digit_display_pwm_if #(
  parameter int N_DIGITS = 8,
  parameter int PWM_BITS = 4
);
  logic [4*N_DIGITS-1:0] number;
  logic [N_DIGITS-1:0]   dots;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  blank_lz;
  logic [PWM_BITS-1:0]   brightness;
  logic [6:0]            seven_segments;
  logic                  dot;
  logic [N_DIGITS-1:0]   anodes;
  logic                  frame_start;

  modport master (
    output number, dots, digit_en, blank_lz, brightness,
    input  seven_segments, dot, anodes, frame_start
  );

  modport slave (
    input  number, dots, digit_en, blank_lz, brightness,
    output seven_segments, dot, anodes, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/mfp_multi_digit_display_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mfp_multi_digit_display_pwm                                     |
// | Brief    : Self-timed N-digit 7-segment multiplexer with PWM brightness.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mfp_multi_digit_display_pwm #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 16384,
  parameter int PWM_BITS    = 4
) (
  input  logic clock,
  input  logic resetn,
  mfp_multi_digit_display_pwm_if.slave bus
);

  localparam int c_P_BITS = $clog2(REFRESH_DIV);
  localparam int c_I_BITS = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_P_BITS-1:0] c_P_LAST = c_P_BITS'(REFRESH_DIV - 1);
  localparam logic [c_I_BITS-1:0] c_I_LAST = c_I_BITS'(N_DIGITS - 1);

  logic [c_P_BITS-1:0]   r_p;
  logic [c_I_BITS-1:0]   r_i;
  logic [4*N_DIGITS-1:0] r_num;
  logic [N_DIGITS-1:0]   r_dots;
  logic [N_DIGITS-1:0]   r_en;
  logic                  r_blz;
  logic [PWM_BITS-1:0]   r_br;
  logic [6:0]            r_seg;
  logic                  r_dot;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_fs;

  logic                  w_cap;
  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_blank;
  logic [PWM_BITS-1:0]   w_phase;
  logic [N_DIGITS-1:0]   w_an;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign w_cap   = (r_p == '0) && (r_i == '0);
  assign w_nib   = r_num[{r_i, 2'b00} +: 4];
  assign w_phase = r_p[c_P_BITS-1 -: PWM_BITS];
  assign w_blank = (r_i != '0) && r_blz && w_lz[r_i];

  // w_lz[k]: every nibble from the top digit down to k is zero
  always_comb begin
    logic w_run;
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      w_run   = w_run & (r_num[4*k +: 4] == 4'h0);
      w_lz[k] = w_run;
    end
  end

  // p == 0 is the anti-ghosting guard cycle of every slot
  always_comb begin
    w_an = '1;
    if ((r_p != '0) && r_en[r_i] && (r_br > w_phase)) begin
      w_an[r_i] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_p    <= '0;
      r_i    <= '0;
      r_num  <= '0;
      r_dots <= '0;
      r_en   <= '0;
      r_blz  <= 1'b0;
      r_br   <= '0;
      r_seg  <= 7'h7F;
      r_dot  <= 1'b1;
      r_an   <= '1;
      r_fs   <= 1'b0;
    end else begin
      if (r_p == c_P_LAST) begin
        r_p <= '0;
        r_i <= (r_i == c_I_LAST) ? '0 : r_i + 1'b1;
      end else begin
        r_p <= r_p + 1'b1;
      end
      if (w_cap) begin
        r_num  <= bus.number;
        r_dots <= bus.dots;
        r_en   <= bus.digit_en;
        r_blz  <= bus.blank_lz;
        r_br   <= bus.brightness;
      end
      r_seg <= w_blank ? 7'h7F : hex_to_seg(w_nib);
      r_dot <= ~r_dots[r_i];
      r_an  <= w_an;
      r_fs  <= w_cap;
    end
  end

  assign bus.seven_segments = r_seg;
  assign bus.dot            = r_dot;
  assign bus.anodes         = r_an;
  assign bus.frame_start    = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_mfp_multi_digit_display_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mfp_multi_digit_display_pwm                                  |
// | Brief    : Scoreboard bench for the PWM multi-digit display driver.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mfp_multi_digit_display_pwm;

  localparam int N   = 4;
  localparam int DIV = 16;
  localparam int PB  = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic       dot;
    logic [3:0] an;
    logic       fs;
  } out_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  mfp_multi_digit_display_pwm_if #(.N_DIGITS(N), .PWM_BITS(PB)) bus ();

  mfp_multi_digit_display_pwm #(.N_DIGITS(N), .REFRESH_DIV(DIV), .PWM_BITS(PB)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_vec = 0;
  int n_err = 0;

  // reference state: slot position and the frame's captured inputs
  int         m_p = 0;
  int         m_i = 0;
  logic [15:0] s_num  = '0;
  logic [3:0]  s_dots = '0;
  logic [3:0]  s_en   = '0;
  logic        s_blz  = 1'b0;
  logic [1:0]  s_br   = '0;
  out_t        sb [$];

  function automatic out_t model_out();
    out_t o;
    int   ph;
    logic blank;
    ph    = m_p / (DIV >> PB);
    blank = (m_i > 0) && s_blz;
    for (int k = m_i; k < N; k++) if (s_num[4*k +: 4] != 4'h0) blank = 1'b0;
    o.seg = blank ? 7'h7F : hex_tab[s_num[4*m_i +: 4]];
    o.dot = ~s_dots[m_i];
    o.an  = 4'hF;
    if (m_p != 0 && s_en[m_i] && int'(s_br) > ph) o.an[m_i] = 1'b0;
    o.fs  = (m_p == 0) && (m_i == 0);
    return o;
  endfunction

  task automatic model_reset();
    m_p = 0; m_i = 0;
    s_num = '0; s_dots = '0; s_en = '0; s_blz = 1'b0; s_br = '0;
    sb.delete();
  endtask

  // one clock: push expectation for the present state, advance, pop against DUT
  task automatic tick(output out_t obs, output out_t exp, output int pp, output int ii);
    sb.push_back(model_out());
    pp = m_p; ii = m_i;
    if (m_p == 0 && m_i == 0) begin
      s_num = bus.number; s_dots = bus.dots; s_en = bus.digit_en;
      s_blz = bus.blank_lz; s_br = bus.brightness;
    end
    if (m_p == DIV - 1) begin m_p = 0; m_i = (m_i + 1) % N; end
    else m_p = m_p + 1;
    @(posedge clock);
    @(negedge clock);
    exp = sb.pop_front();
    obs = {bus.seven_segments, bus.dot, bus.anodes, bus.frame_start};
  endtask

  task automatic advance_to(input int p, input int i);
    out_t o, e;
    int   pp, ii, guard;
    guard = 0;
    while (!(m_p == p && m_i == i)) begin
      tick(o, e, pp, ii);
      guard++;
      if (guard > 300) begin
        n_vec++; n_err++;
        $display("FAIL advance_to timeout: at p=%0d i=%0d, wanted p=%0d i=%0d", m_p, m_i, p, i);
        return;
      end
    end
  endtask

  task automatic set_inputs(input logic [15:0] num, input logic [3:0] dt,
                            input logic [3:0] en, input logic blz, input logic [1:0] br);
    bus.number = num; bus.dots = dt; bus.digit_en = en;
    bus.blank_lz = blz; bus.brightness = br;
  endtask

  task automatic test_reset();
    out_t o, e;
    int   pp, ii, fs_cnt;
    set_inputs(16'h0000, 4'h0, 4'hF, 1'b0, 2'd3);
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    o = {bus.seven_segments, bus.dot, bus.anodes, bus.frame_start};
    n_vec++;
    if (o !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL reset_state: got %h required %h", o, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    model_reset();
    resetn = 1'b1;
    fs_cnt = 0;
    for (int c = 0; c < 130; c++) begin
      tick(o, e, pp, ii);
      if (o.fs) fs_cnt++;
      if (c == 0) begin
        n_vec++;
        if (o.fs !== 1'b1) begin n_err++; $display("FAIL first_frame_start: got %b required 1", o.fs); end
      end
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset_run p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
    end
    n_vec++;
    if (fs_cnt != 3) begin n_err++; $display("FAIL frame_period: got %0d pulses required 3", fs_cnt); end
  endtask

  task automatic test_scan();
    out_t       o, e;
    int         pp, ii, lows;
    logic [6:0] seg_at [4];
    logic [6:0] want   [4];
    want = '{7'b0001110, 7'b1000000, 7'b0001000, 7'b0110000};
    set_inputs(16'h3A0F, 4'h0, 4'hF, 1'b0, 2'd3);
    advance_to(0, 0);
    tick(o, e, pp, ii);
    lows = 0;
    for (int c = 0; c < 64; c++) begin
      tick(o, e, pp, ii);
      if (o.an != 4'hF) lows++;
      if (pp == 5) seg_at[ii] = o.seg;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL scan p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
    end
    n_vec++;
    if (lows != 44) begin n_err++; $display("FAIL scan_duty: got %0d lit cycles required 44", lows); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (seg_at[k] !== want[k]) begin
        n_err++; $display("FAIL scan_seg digit %0d: got %b required %b", k, seg_at[k], want[k]);
      end
    end
  endtask

  task automatic test_brightness();
    out_t o, e;
    int   pp, ii, lows;
    for (int b = 1; b >= 0; b--) begin
      set_inputs(16'h3A0F, 4'h0, 4'hF, 1'b0, 2'(b));
      advance_to(0, 0);
      tick(o, e, pp, ii);
      lows = 0;
      for (int c = 0; c < 64; c++) begin
        tick(o, e, pp, ii);
        if (o.an != 4'hF) lows++;
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL bright%0d p=%0d i=%0d: got %h required %h", b, pp, ii, o, e); end
      end
      n_vec++;
      if (lows != b * 12) begin
        n_err++; $display("FAIL bright%0d_duty: got %0d lit cycles required %0d", b, lows, b * 12);
      end
    end
  endtask

  task automatic test_blanking();
    out_t       o, e;
    int         pp, ii;
    logic [7:0] at   [4];
    logic [7:0] want [4];
    want = '{{7'b0010010, 1'b1}, {7'h7F, 1'b1}, {7'h7F, 1'b0}, {7'h7F, 1'b1}};
    set_inputs(16'h0005, 4'b0100, 4'hF, 1'b1, 2'd3);
    advance_to(0, 0);
    tick(o, e, pp, ii);
    for (int c = 0; c < 64; c++) begin
      tick(o, e, pp, ii);
      if (pp == 5) at[ii] = {o.seg, o.dot};
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL blank p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (at[k] !== want[k]) begin
        n_err++; $display("FAIL blank_digit %0d: got %h required %h", k, at[k], want[k]);
      end
    end
    set_inputs(16'h0000, 4'b0000, 4'hF, 1'b1, 2'd3);
    advance_to(0, 0);
    tick(o, e, pp, ii);
    for (int c = 0; c < 64; c++) begin
      tick(o, e, pp, ii);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL blank_zero p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
      if (pp == 5 && ii == 0) begin
        n_vec++;
        if (o.seg !== 7'b1000000) begin n_err++; $display("FAIL zero_digit0: got %b required 1000000", o.seg); end
      end
    end
  endtask

  task automatic test_coherence();
    out_t       o, e;
    int         pp, ii, fr;
    logic [6:0] old_seg [4];
    logic [6:0] new_seg0;
    set_inputs(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3);
    advance_to(0, 0);
    tick(o, e, pp, ii);
    advance_to(5, 2);
    bus.number = 16'hABCD;
    fr = 0;
    for (int c = 0; c < 120; c++) begin
      tick(o, e, pp, ii);
      if (pp == 0 && ii == 0) fr++;
      if (pp == 6 && fr == 0) old_seg[ii] = o.seg;
      if (pp == 6 && ii == 0 && fr == 1) new_seg0 = o.seg;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL coherence p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
    end
    n_vec++;
    if (old_seg[2] !== 7'b0100100 || old_seg[3] !== 7'b1111001) begin
      n_err++; $display("FAIL coherence_old: got %b %b required 0100100 1111001", old_seg[2], old_seg[3]);
    end
    n_vec++;
    if (new_seg0 !== 7'b0100001) begin n_err++; $display("FAIL coherence_new: got %b required 0100001", new_seg0); end
  endtask

  task automatic test_enable_reset();
    out_t o, e;
    int   pp, ii, lows, others;
    set_inputs(16'h5678, 4'h0, 4'b0001, 1'b0, 2'd3);
    advance_to(0, 0);
    tick(o, e, pp, ii);
    lows = 0; others = 0;
    for (int c = 0; c < 64; c++) begin
      tick(o, e, pp, ii);
      if (o.an != 4'hF) lows++;
      if (o.an[3:1] != 3'b111) others++;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL enable p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
    end
    n_vec++;
    if (lows != 11 || others != 0) begin
      n_err++; $display("FAIL enable_only0: got lit=%0d other=%0d required 11 0", lows, others);
    end
    advance_to(7, 2);
    resetn = 1'b0;
    #1;
    o = {bus.seven_segments, bus.dot, bus.anodes, bus.frame_start};
    n_vec++;
    if (o !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      n_err++; $display("FAIL async_reset: got %h required %h", o, {7'h7F, 1'b1, 4'hF, 1'b0});
    end
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 70; c++) begin
      tick(o, e, pp, ii);
      if (c == 0) begin
        n_vec++;
        if (o.fs !== 1'b1) begin n_err++; $display("FAIL restart_frame_start: got %b required 1", o.fs); end
      end
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL restart p=%0d i=%0d: got %h required %h", pp, ii, o, e); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_blanking();
    test_coherence();
    test_enable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
